fp_add_sched: RTL and testbench

Scheduler that shares one `fp_adder` instance among `N_REQ` requesters. It grants access round-robin and issues one operation at a time to the adder. Because the adder's latency depends on the operands and the adder has no done signal, the scheduler predicts that latency, captures the result in the adder's FINISH cycle, and returns it to the granted requester over a valid/ready response handshake. The block sits between the requesters and the adder, and it owns the adder's synchronous reset and `data_valid` pulse.

---
 rtl/fp_sched_pkg.sv | 23 ++
 rtl/fp_add_sched_rr_arbiter.sv | 41 ++++
 rtl/fp_add_sched.sv | 151 +++++++++++++++
 tb/tb_fp_add_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared types and constants for the fp_add_sched slice.
// Latencies are counted from ISSUE to the adder's FINISH cycle.
package fp_sched_pkg;

  typedef enum logic [2:0] {
    INIT,
    ARB,
    ISSUE,
    WAIT,
    RESP
  } fps_state_t;

  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] LAT_NORMAL = 3'd4;
  localparam logic [CNT_W-1:0] LAT_EXC    = 3'd2;
  localparam logic [7:0]       EXP_SPECIAL = 8'hFF;

  function automatic logic is_special(input logic [31:0] f);
    return f[30:23] == EXP_SPECIAL;
  endfunction

endpackage

// File: rtl/fp_add_sched_rr_arbiter.sv
// rr_arbiter: one-hot grant, round-robin after last_grant by default.
// FP_ADD_SCHED_FIXED_PRIO_EN switches to lowest-index-wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
`ifndef FP_ADD_SCHED_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] last_grant,
`endif
  output logic [N_REQ-1:0] gnt
);

`ifdef FP_ADD_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] idx;

  // Scan farthest offset first so the nearest one after last_grant wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (req_valid[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fp_add_sched.sv
// fp_add_sched: shares one fp_adder among N_REQ requesters.
// Define FP_ADD_SCHED_FIXED_PRIO_EN for fixed priority arbitration.
module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [31:0]         rsp_sum,
  output logic               rsp_error,
  output logic               fa_rst,
  output logic               fa_valid,
  output logic [31:0]         fa_a,
  output logic [31:0]         fa_b,
  input  logic [31:0]         fa_sum,
  input  logic               fa_error
);

  fps_state_t state_q, state_d;

  logic [IDX_W-1:0] g_q, g_d, gidx;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      sel_a, sel_b;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt;

`ifndef FP_ADD_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0] last_q, last_d;
`endif

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .req_valid (req_valid),
`ifndef FP_ADD_SCHED_FIXED_PRIO_EN
    .last_grant(last_q),
`endif
    .gnt       (gnt)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    gidx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*32 +: 32];
        sel_b = req_b[i*32 +: 32];
        gidx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifndef FP_ADD_SCHED_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      INIT: state_d = ARB;
      ARB: begin
        if (|gnt) begin
          g_d     = gidx;
          a_d     = sel_a;
          b_d     = sel_b;
`ifndef FP_ADD_SCHED_FIXED_PRIO_EN
          last_d  = gidx;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = (is_special(a_q) || is_special(b_q)) ?
                  LAT_EXC : LAT_NORMAL;
        state_d = WAIT;
      end
      // A count of 1 marks the adder's FINISH cycle.
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          sum_d   = fa_sum;
          err_d   = fa_error;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[g_q]) state_d = ARB;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      g_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifndef FP_ADD_SCHED_FIXED_PRIO_EN
      last_q  <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifndef FP_ADD_SCHED_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign fa_rst    = (state_q == INIT);
  assign fa_valid  = (state_q == ISSUE);
  assign fa_a      = a_q;
  assign fa_b      = b_q;
  assign rsp_sum   = sum_q;
  assign rsp_error = err_q;

  always_comb begin
    req_ready = (state_q == ARB) ? gnt : '0;
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (g_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_fp_add_sched.sv
// tb_fp_add_sched: cycle-level transaction model plus adder stand-in,
// with directed vectors and literal expectations for fp_add_sched.
module tb_fp_add_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_ready, rsp_valid, rsp_ready;
  logic [31:0]     rsp_sum, fa_a, fa_b;
  logic            rsp_error, fa_rst, fa_valid;
  logic [31:0]     fa_sum = 32'hDEADBEEF;
  logic            fa_error = 1'b1;

  int checks = 0;
  int errors = 0;

  fp_add_sched #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_error(rsp_error), .fa_rst(fa_rst),
    .fa_valid(fa_valid), .fa_a(fa_a), .fa_b(fa_b),
    .fa_sum(fa_sum), .fa_error(fa_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic spec_exp(input logic [31:0] f);
    return f[30:23] == 8'hFF;
  endfunction

  // Reference adder for the directed operand pairs; returns {error,sum}.
  function automatic logic [32:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] k;
    if (spec_exp(a) || spec_exp(b)) begin
      if ((spec_exp(a) && a[22:0] != 0) || (spec_exp(b) && b[22:0] != 0))
        return {1'b1, 32'h7FFFFFFF};
      return {1'b0, spec_exp(a) ? a : b};
    end
    k = (a < b) ? {a, b} : {b, a};
    case (k)
      64'h3F800000_40000000: return {1'b0, 32'h40400000};
      64'h3F800000_3F800000: return {1'b0, 32'h40000000};
      64'h40000000_40400000: return {1'b0, 32'h40A00000};
      64'h40400000_40400000: return {1'b0, 32'h40C00000};
      64'h40800000_40800000: return {1'b0, 32'h41000000};
      default:               return {1'b0, 32'h00000000};
    endcase
  endfunction

  // Transaction-level model: grant times, latencies and round-robin pointer.
  int          cyc = -1;
  bit          busy = 0;
  int          t_gnt, lat, g = 0, last = N - 1, arb_cyc = 1;
  logic [31:0] ea = '0, eb = '0;
  int          fin = -10;
  logic [32:0] fres;

  always @(negedge clk) begin
    logic [N-1:0] e_rdy, e_rv;
    logic         e_fv;
    int           gi;
    if (!rst) begin
      cyc = -1; busy = 0; last = N - 1; arb_cyc = 1;
      ea = '0; eb = '0; fin = -10;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_fa_valid", fa_valid, 0);
      chk("rst_fa_a", fa_a, 0);
      chk("rst_fa_b", fa_b, 0);
      chk("rst_fa_rst", fa_rst, 1);
      fa_sum = 32'hDEADBEEF; fa_error = 1'b1;
    end else begin
      cyc++;
      e_rdy = '0; e_rv = '0; gi = 0;
      e_fv = busy && (cyc == t_gnt + 1);
      if (!busy && cyc >= arb_cyc && |req_valid) begin
        for (int k = N; k >= 1; k--)
          if (req_valid[(last + k) % N]) gi = (last + k) % N;
        e_rdy[gi] = 1'b1;
      end
      if (busy && cyc > t_gnt + 1 + lat) e_rv[g] = 1'b1;
      chk("req_ready", req_ready, e_rdy);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("fa_valid", fa_valid, e_fv);
      chk("fa_rst", fa_rst, cyc == 0);
      chk("fa_a", fa_a, ea);
      chk("fa_b", fa_b, eb);
      if (e_rv != 0) begin
        fres = fadd(ea, eb);
        chk("rsp_sum", rsp_sum, fres[31:0]);
        chk("rsp_error", rsp_error, fres[32]);
      end
      if (e_rdy != 0) begin
        busy = 1; t_gnt = cyc; g = gi; last = gi;
        ea = req_a[gi*32 +: 32];
        eb = req_b[gi*32 +: 32];
        lat = (spec_exp(ea) || spec_exp(eb)) ? 2 : 4;
      end else if (e_rv != 0 && rsp_ready[g]) begin
        busy = 0; arb_cyc = cyc + 1;
      end
      // Adder stand-in: result visible only in its FINISH cycle.
      if (fa_valid) begin
        fin = cyc + ((spec_exp(fa_a) || spec_exp(fa_b)) ? 2 : 4);
        fres = fadd(fa_a, fa_b);
        {fa_error, fa_sum} = {1'b1, 32'hDEADBEEF};
      end else if (cyc == fin) begin
        {fa_error, fa_sum} = fadd(fa_a, fa_b);
      end else begin
        {fa_error, fa_sum} = {1'b1, 32'hDEADBEEF};
      end
    end
  end

  task automatic wait_grant(input int i, output bit ok);
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout req=%0d", i);
    end
  endtask

  task automatic do_op(input int i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] s,
                       input logic e, input int el, input bit hold);
    bit ok;
    int n;
    if (hold) rsp_ready = ~(4'b0001 << i);
    req_valid[i] = 1'b1;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    wait_grant(i, ok);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (!ok) return;
    n = 0; ok = 0;
    while (!ok && n < 30) begin
      n++;
      @(negedge clk);
      if (rsp_valid[i]) ok = 1;
    end
    chk("op_latency", n, el);
    chk("op_sum", rsp_sum, s);
    chk("op_error", rsp_error, e);
    if (hold) begin
      repeat (3) @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 4'b0001 << i);
      chk("hold_rsp_sum", rsp_sum, s);
      @(posedge clk); #1;
      rsp_ready = '1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int order[5];
    int ng, nfv, last_fv, minsp, n;
    bit ok;
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("fa_rst_first_cycle", fa_rst, 1);
    @(negedge clk);
    chk("fa_rst_second_cycle", fa_rst, 0);
    repeat (3) @(negedge clk);
    chk("idle_fa_valid", fa_valid, 0);
    @(posedge clk); #1;

    do_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 6, 1);
    do_op(1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 4, 0);
    do_op(3, 32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 1'b1, 4, 0);

    req_a = {32'h40800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    req_b = {32'h40800000, 32'h3F800000, 32'h40400000, 32'h40000000};
    req_valid = 4'hF;
    ng = 0; nfv = 0; last_fv = -1; minsp = 1000; n = 0;
    while (nfv < 5 && n < 200) begin
      @(negedge clk); n++;
      if (|req_ready && ng < 5) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) order[ng] = k;
        ng++;
      end
      if (fa_valid) begin
        if (last_fv >= 0 && n - last_fv < minsp) minsp = n - last_fv;
        last_fv = n; nfv++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_grant_count", ng, 5);
    for (int k = 0; k < 5; k++) chk("rr_order", order[k], k % 4);
    chk("rr_min_spacing", minsp, 7);
    repeat (12) @(posedge clk); #1;

    req_a[32 +: 32] = 32'h40800000;
    req_b[32 +: 32] = 32'h40800000;
    req_valid[1] = 1'b1;
    wait_grant(1, ok);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_fa_rst", fa_rst, 1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (|rsp_valid) n++;
    end
    chk("mid_rst_no_rsp", n, 0);
    @(posedge clk); #1;
    do_op(2, 32'h40400000, 32'h40400000, 32'h40C00000, 1'b0, 6, 0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
